fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch front end of the MIPS pipeline. Owns the PC and drives the
//  byte address into the instruction memory, which returns the 32-bit word one
//  clock later (registered read).
//  Tracks which PC each returned word belongs to. Handles stall, branch/jump
//  redirect and squash, and presents a valid-qualified IF/ID bundle to decode.
// PARAMETERS
//  PC_W      8   PC / byte-address width; all PC arithmetic is modulo 2**PC_W
//  INSTR_W   32  instruction width (4 bytes, big-endian word in memory)
//  RESET_PC  0   first fetch address after reset; must be word aligned
//  CNT_W     16  width of the delivered-instruction counter
// PORTS
//  clk             in   1        clock, all state on posedge
//  rst             in   1        reset, synchronous, active-high
//  imem_addr       out  PC_W     byte address to instruction memory (combinational)
//  imem_instr      in   INSTR_W  word read at the previous edge's imem_addr
//  id_stall        in   1        decode cannot accept; hold the current bundle
//  redirect_valid  in   1        taken branch/jump this cycle
//  redirect_pc     in   PC_W     redirect target byte address
//  id_valid        out  1        id_instr/id_pc/id_pc4 hold a real instruction
//  id_instr        out  INSTR_W  instruction to decode
//  id_pc           out  PC_W     byte address of id_instr
//  id_pc4          out  PC_W     id_pc + 4 (wraps)
//  misalign        out  1        1-cycle pulse: redirect_pc[1:0] != 0
//  fetch_count     out  CNT_W    instructions handed to decode, saturating
// BEHAVIOUR
//  State: fetch_pc_q (next address to fetch), rsp_pc_q and rsp_valid_q (tag of
//   the word now on imem_instr), misalign_q, count_q.
//  Reset (rst=1 at an edge): fetch_pc_q=RESET_PC, rsp_pc_q=0, rsp_valid_q=0,
//   misalign_q=0, count_q=0. While rst=1, id_valid=0 and imem_instr is ignored.
//  tgt = {redirect_pc[PC_W-1:2],2'b00}; low bits are always forced to zero.
//  imem_addr: redirect_valid ? tgt : id_stall ? rsp_pc_q : fetch_pc_q.
//  Outputs:
//   - id_instr = imem_instr
//   - id_pc = rsp_pc_q; id_pc4 = rsp_pc_q+4
//   - id_valid = rsp_valid_q & ~redirect_valid (wrong-path word squashed the
//     same cycle)
//  Edge update, priority rst > redirect > stall > normal:
//   - redirect: rsp_pc_q=tgt, rsp_valid_q=1, fetch_pc_q=tgt+4. Target word
//     appears next cycle (zero-bubble redirect).
//   - stall: fetch_pc_q and rsp_* hold. Memory re-reads rsp_pc_q, so the same
//     word reappears next cycle; outputs are stable across any stall length.
//   - normal: rsp_pc_q=fetch_pc_q, rsp_valid_q=1, fetch_pc_q=fetch_pc_q+4.
//  First valid word: second cycle after rst deasserts (1-cycle memory latency).
//  Wrap-around: 0xFC+4 = 0x00, no flag.
//  Redirect with stall in the same cycle: redirect wins; stall is ignored.
//  misalign_q = redirect_valid & |redirect_pc[1:0]; registered, so it is
//   visible one cycle after the redirect.
//  count_q += 1 when id_valid & ~id_stall; holds at all-ones.
//  Latency: imem_addr -> id_instr is 1 cycle. Throughput: 1 instruction/cycle
//   without stalls.
// STRUCTURE
//  mips_pkg: PC_W, INSTR_W, INSTR_BYTES=4, NOP_INSTR=32'h0.
//  One sub-module: fetch_sat_counter (CNT_W saturating counter with enable,
//   sync reset); reused later for pipeline performance counters.
//  PC tag/redirect logic stays flat in fetch_unit.
// TESTING
//  1. rst 2 cycles, release, no stall -> imem_addr 00,04,08..; id_valid first
//     high 2nd cycle after release with id_pc=00,id_pc4=04, then +4 each cycle.
//  2. id_stall high 3 cycles while id_pc=08 -> imem_addr=08, id_instr/id_pc
//     stable for 3 cycles, then 0C next; fetch_count unchanged during stall.
//  3. redirect_valid=1 with pc 0x40 while id_pc=10 -> id_valid=0 that cycle,
//     next cycle id_pc=40 valid, then 44.
//  4. redirect 0x22 together with id_stall=1 -> redirect wins, next id_pc=20,
//     misalign=1 exactly one cycle later.
//  5. redirect to 0xF8, run -> id_pc F8,FC,00,04; id_pc4 at FC is 00.
//  6. CNT_W=4, 20 unstalled instructions -> fetch_count sticks at 4'hF; rst
//     mid-run -> count 0, id_valid 0 next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline widths and constants
package mips_pkg;

    localparam int PC_W = 8;
    localparam int INSTR_W = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_sat_counter.sv
// rtl/fetch_sat_counter.sv - saturating event counter with enable and sync reset
module fetch_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // count enabled events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end with PC tagging, stall and redirect
module fetch_unit
    import mips_pkg::*;
#(
    parameter int                    PC_W     = mips_pkg::PC_W,
    parameter int                    INSTR_W  = mips_pkg::INSTR_W,
    parameter logic [PC_W-1:0]       RESET_PC = '0,
    parameter int                    CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               id_stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc4,
    output logic               misalign,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [PC_W-1:0] STEP = PC_W'(INSTR_BYTES);

    logic [PC_W-1:0] fetch_pc_q;
    logic [PC_W-1:0] rsp_pc_q;
    logic            rsp_valid_q;
    logic            misalign_q;
    logic [PC_W-1:0] tgt;
    logic            deliver;

    // word-align the redirect target; memory is always read on word boundaries
    always_comb begin
        tgt = {redirect_pc[PC_W-1:2], 2'b00};
    end

    // address mux: redirect jumps immediately, stall re-reads the held word
    always_comb begin
        imem_addr = fetch_pc_q;
        if (redirect_valid) begin
            imem_addr = tgt;
        end else if (id_stall) begin
            imem_addr = rsp_pc_q;
        end
    end

    // IF/ID bundle; the word on the bus is wrong-path when a redirect is taken now
    always_comb begin
        id_instr = imem_instr;
        id_pc    = rsp_pc_q;
        id_pc4   = rsp_pc_q + STEP;
        id_valid = rsp_valid_q & ~redirect_valid & ~rst;
        misalign = misalign_q;
        deliver  = id_valid & ~id_stall;
    end

    // PC and response-tag registers, priority reset > redirect > stall > advance
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= '0;
            rsp_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= redirect_valid & (|redirect_pc[1:0]);
            if (redirect_valid) begin
                rsp_pc_q    <= tgt;
                rsp_valid_q <= 1'b1;
                fetch_pc_q  <= tgt + STEP;
            end else if (!id_stall) begin
                rsp_pc_q    <= fetch_pc_q;
                rsp_valid_q <= 1'b1;
                fetch_pc_q  <= fetch_pc_q + STEP;
            end
        end
    end

    fetch_sat_counter #(
        .W(CNT_W)
    ) u_count (
        .clk  (clk),
        .rst  (rst),
        .en   (deliver),
        .count(fetch_count)
    );

endmodule
